mux_scan_ctrl: RTL and testbench

- Sequencer that drives the 3-bit select of the 8:1 channel mux and consumes its 1-bit output y.
- Walks the enabled channels in ascending order, holds each select for a fixed dwell, and samples y after a settle time.
- Assembles the samples into an 8-bit snapshot and presents it downstream on a valid/ready handshake.
- Supports single-shot and continuous scanning.

---
 rtl/mux_scan_ctrl.sv | 126 ++++++++++++
 tb/tb_mux_scan_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an 8:1 channel mux: walks enabled selects, samples y, emits a snapshot.
// Optional MUX_SCAN_PARITY_EN adds snap_par, the XOR of snap, registered alongside it.
module mux_scan_ctrl #(
  parameter int DWELL  = 4,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic [7:0] chan_mask,
  output logic [2:0] s,
  input  logic       y,
  output logic [7:0] snap,
  output logic       snap_valid,
  input  logic       snap_ready,
  output logic       busy
`ifdef MUX_SCAN_PARITY_EN
  , output logic     snap_par
`endif
);
  localparam int NCH = 8;

  typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

  state_t           state, state_d;
  logic [2:0]       s_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [NCH-1:0]   mask_q, mask_d, smp, smp_d, snap_d, hi;
  logic             snap_valid_d;

  function automatic logic [2:0] lowest(input logic [NCH-1:0] m);
    lowest = '0;
    for (int k = NCH-1; k >= 0; k--)
      if (m[k]) lowest = 3'(k);
  endfunction

  // enabled channels strictly above the current select; empty means the pass is done
  always_comb begin
    hi = '0;
    for (int k = 0; k < NCH; k++)
      hi[k] = mask_q[k] && (3'(k) > s);
  end

  always_comb begin
    state_d      = state;
    s_d          = s;
    cnt_d        = cnt;
    mask_d       = mask_q;
    smp_d        = smp;
    snap_d       = snap;
    snap_valid_d = snap_valid;
    case (state)
      IDLE: begin
        if (start && |chan_mask) begin
          mask_d  = chan_mask;
          s_d     = lowest(chan_mask);
          cnt_d   = '0;
          smp_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        cnt_d = cnt + CNT_W'(1);
        if (cnt == CNT_W'(SETTLE-1)) smp_d[s] = y;
        if (cnt == CNT_W'(DWELL-1)) begin
          cnt_d = '0;
          if (|hi) begin
            s_d = lowest(hi);
          end else begin
            snap_d       = smp_d;
            snap_valid_d = 1'b1;
            state_d      = OUT;
          end
        end
      end
      OUT: begin
        if (snap_valid && snap_ready) begin
          snap_valid_d = 1'b0;
          if (cont && |chan_mask) begin
            mask_d  = chan_mask;
            s_d     = lowest(chan_mask);
            cnt_d   = '0;
            smp_d   = '0;
            state_d = SCAN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      s          <= '0;
      cnt        <= '0;
      mask_q     <= '0;
      smp        <= '0;
      snap       <= '0;
      snap_valid <= 1'b0;
    end else begin
      state      <= state_d;
      s          <= s_d;
      cnt        <= cnt_d;
      mask_q     <= mask_d;
      smp        <= smp_d;
      snap       <= snap_d;
      snap_valid <= snap_valid_d;
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  // snap_d only moves on a snapshot load, so parity tracks snap exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) snap_par <= 1'b0;
    else        snap_par <= ^snap_d;
  end
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: directed scans queue expected snapshots and rise cycles.
module tb_mux_scan_ctrl;
  logic       clk, rst_n, start, cont, y, snap_valid, snap_ready, busy;
  logic [7:0] chan_mask, snap, i_vec;
  logic [2:0] s;
`ifdef MUX_SCAN_PARITY_EN
  logic       snap_par;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] snap;
    int         rise;
  } exp_t;
  exp_t q[$];

  mux_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .chan_mask(chan_mask),
    .s(s), .y(y), .snap(snap), .snap_valid(snap_valid), .snap_ready(snap_ready),
    .busy(busy)
`ifdef MUX_SCAN_PARITY_EN
    , .snap_par(snap_par)
`endif
  );

  // 8:1 mux model
  assign y = i_vec[s];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: pops and compares on every handshake
  logic vld_q = 1'b0;
  int   rise_cyc = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      vld_q = 1'b0;
    end else begin
      if (snap_valid && !vld_q) rise_cyc = cyc;
      vld_q = snap_valid;
      if (snap_valid && snap_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_snapshot", {24'd0, snap}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("snap", {24'd0, snap}, {24'd0, e.snap});
          chk("valid_rise_edge", rise_cyc, e.rise);
`ifdef MUX_SCAN_PARITY_EN
          chk("snap_par", {31'd0, snap_par}, {31'd0, ^e.snap});
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  task automatic push(input logic [7:0] sn, input int rise);
    exp_t e;
    e.snap = sn;
    e.rise = rise;
    q.push_back(e);
  endtask

  // start is sampled at edge n; returns just after edge n
  task automatic start_scan(input logic [7:0] m, input logic [7:0] iv, output int n);
    chan_mask = m;
    i_vec     = iv;
    start     = 1'b1;
    n         = cyc + 1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout reached at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; cont = 1'b0; chan_mask = 8'h00;
    snap_ready = 1'b1; i_vec = 8'h00;
    #3;
    chk("rst_s", {29'd0, s}, 0);
    chk("rst_snap", {24'd0, snap}, 0);
    chk("rst_valid", {31'd0, snap_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // full scan; mask changed mid-scan must be ignored
    start_scan(8'hFF, 8'hD6, n);
    push(8'hD6, n + 32);
    chk("full_busy", {31'd0, busy}, 1);
    chan_mask = 8'h01;
    for (int j = 0; j < 8; j++) begin
      wait_cyc(n + 4*j);
      chk("full_s", {29'd0, s}, j);
    end
    wait_cyc(n + 33);
    chk("full_busy_after", {31'd0, busy}, 0);
    chk("full_valid_after", {31'd0, snap_valid}, 0);
    chk("full_snap_held", {24'd0, snap}, 32'hD6);

    // masked scan, low nibble
    start_scan(8'h0F, 8'hD6, n);
    push(8'h06, n + 16);
    for (int j = 0; j < 4; j++) begin
      wait_cyc(n + 4*j);
      chk("mask0f_s", {29'd0, s}, j);
    end
    wait_cyc(n + 17);
    chk("mask0f_busy_after", {31'd0, busy}, 0);

    // sparse mask: 0 then 7
    start_scan(8'h81, 8'hD6, n);
    push(8'h80, n + 8);
    chk("mask81_s0", {29'd0, s}, 0);
    wait_cyc(n + 4);
    chk("mask81_s7", {29'd0, s}, 7);
    wait_cyc(n + 9);
    chk("mask81_busy_after", {31'd0, busy}, 0);

    // backpressure for 20 cycles
    snap_ready = 1'b0;
    start_scan(8'hFF, 8'hD6, n);
    push(8'hD6, n + 32);
    wait_cyc(n + 32);
    for (int j = 0; j < 20; j++) begin
      chk("bp_valid", {31'd0, snap_valid}, 1);
      chk("bp_snap", {24'd0, snap}, 32'hD6);
      chk("bp_s", {29'd0, s}, 7);
      tick();
    end
    snap_ready = 1'b1;
    tick();
    chk("bp_valid_after", {31'd0, snap_valid}, 0);
    chk("bp_busy_after", {31'd0, busy}, 0);
    tick();
    chk("bp_single_hs", {31'd0, busy}, 0);

    // continuous: two passes, cont dropped before the second handshake
    cont = 1'b1;
    start_scan(8'hFF, 8'hD6, n);
    push(8'hD6, n + 32);
    wait_cyc(n + 32);
    i_vec = 8'h3C;
    push(8'h3C, n + 65);
    wait_cyc(n + 33);
    chk("cont_rescan_busy", {31'd0, busy}, 1);
    chk("cont_rescan_s", {29'd0, s}, 0);
    wait_cyc(n + 40);
    cont = 1'b0;
    wait_cyc(n + 66);
    chk("cont_idle_after", {31'd0, busy}, 0);

    // start with empty mask is ignored
    chan_mask = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mask0_busy", {31'd0, busy}, 0);
    tick();
    chk("mask0_busy2", {31'd0, busy}, 0);

    // start during scan is neither a restart nor queued
    start_scan(8'hFF, 8'hA5, n);
    push(8'hA5, n + 32);
    wait_cyc(n + 10);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_cyc(n + 33);
    chk("restart_busy_after", {31'd0, busy}, 0);
    tick();
    chk("restart_not_queued", {31'd0, busy}, 0);

    // async reset mid-scan, between clock edges
    start_scan(8'hFF, 8'h5A, n);
    wait_cyc(n + 10);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_s", {29'd0, s}, 0);
    chk("midrst_snap", {24'd0, snap}, 0);
    chk("midrst_valid", {31'd0, snap_valid}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (40) tick();
    chk("midrst_no_snapshot", {31'd0, snap_valid}, 0);

    for (int k = 0; k < 200 && q.size() != 0; k++) tick();
    chk("scoreboard_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
